// File: rtl/softmax_result_writer_pkg.sv
// Shared constants for the softmax result write-back path: datapath widths and FSM state encoding.
// Widths come from the DATAWIDTH / NUM / ADDRSIZE defines, with local defaults when they are absent.
`ifndef DATAWIDTH
`define DATAWIDTH 32
`endif
`ifndef NUM
`define NUM 2
`endif
`ifndef ADDRSIZE
`define ADDRSIZE 9
`endif

package softmax_result_writer_pkg;
  localparam int DATAWIDTH = `DATAWIDTH;
  localparam int NUM       = `NUM;
  localparam int ADDRSIZE  = `ADDRSIZE;
  localparam int WORDWIDTH = DATAWIDTH * NUM;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;
  localparam logic [1:0] ST_COMPLETE = 2'd3;

  // Wrapping sum of all lanes of one packed memory word.
  function automatic logic [DATAWIDTH-1:0] lane_sum(input logic [WORDWIDTH-1:0] word);
    logic [DATAWIDTH-1:0] s;
    s = '0;
    for (int i = 0; i < NUM; i++) s = s + word[i*DATAWIDTH +: DATAWIDTH];
    return s;
  endfunction
endpackage

// File: rtl/softmax_wb_fifo.sv
// Registered synchronous FIFO buffering packed result words; flush empties it in one cycle.
// The head is read combinationally; push and pop in the same cycle are legal even when full.
module softmax_wb_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      cnt;

  assign head  = mem[rd_ptr];
  assign full  = (cnt == DEPTH[AW:0]);
  assign empty = (cnt == '0);
  assign count = cnt;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Storage carries no reset; occupancy alone says which slots hold valid data.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/softmax_result_writer.sv
// Softmax result write-back: captures lane results on sm_done, buffers them and writes packed words to memory.
// Optional WR_CHECKSUM_EN adds a running wrapping sum of every lane written; otherwise checksum is tied to 0.
module softmax_result_writer
  import softmax_result_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [ADDRSIZE-1:0]   out_start_addr,
  input  logic [ADDRSIZE-1:0]   out_end_addr,
  input  logic [DATAWIDTH-1:0]  outp0,
  input  logic [DATAWIDTH-1:0]  outp1,
  input  logic                  sm_done,
  output logic                  mem_wr_en,
  output logic [ADDRSIZE-1:0]   mem_wr_addr,
  output logic [WORDWIDTH-1:0]  mem_wr_data,
  input  logic                  mem_wr_ready,
  output logic                  busy,
  output logic                  complete,
  output logic [ADDRSIZE:0]     beat_count,
  output logic                  fifo_ovf,
  output logic                  addr_ovr,
  output logic [DATAWIDTH-1:0]  checksum,
  output logic [1:0]            fsm_state
);
  // Write port handshake: mem_wr_en/addr/data are held until a cycle where mem_wr_en & mem_wr_ready,
  // which is the accept edge; nothing changes on the port while ready is low.
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]           state;
  logic [ADDRSIZE:0]    wr_ptr;
  logic [ADDRSIZE-1:0]  end_addr;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [WORDWIDTH-1:0] fifo_head;
  logic [ADDRSIZE:0]    target;
  logic                 capture;
  logic                 target_bad;
  logic                 accept;
  logic                 push;

  assign capture    = !init && sm_done && ((state == ST_ARMED) || (state == ST_RUN));
  assign mem_wr_en  = (state == ST_RUN) && !fifo_empty;
  assign accept     = mem_wr_en && mem_wr_ready;
  // Address this beat would land on once everything already buffered has been written.
  assign target     = wr_ptr + {{(ADDRSIZE + 1 - CW){1'b0}}, fifo_count};
  assign target_bad = (target > {1'b0, end_addr});
  assign push       = capture && !target_bad && (!fifo_full || accept);

  assign mem_wr_addr = wr_ptr[ADDRSIZE-1:0];
  assign mem_wr_data = mem_wr_en ? fifo_head : '0;
  assign busy        = (state == ST_ARMED) || (state == ST_RUN);
  assign complete    = (state == ST_COMPLETE);
  assign fsm_state   = state;

  softmax_wb_fifo #(
    .WIDTH (WORDWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (init),
    .push  (push),
    .pop   (accept),
    .din   ({outp1, outp0}),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      end_addr   <= '0;
      beat_count <= '0;
      fifo_ovf   <= 1'b0;
      addr_ovr   <= 1'b0;
    end else if (init) begin
      state      <= ST_ARMED;
      wr_ptr     <= {1'b0, out_start_addr};
      end_addr   <= out_end_addr;
      beat_count <= '0;
      fifo_ovf   <= 1'b0;
      addr_ovr   <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr     <= wr_ptr + 1'b1;
        beat_count <= beat_count + 1'b1;
      end
      if (capture && target_bad)                    addr_ovr <= 1'b1;
      else if (capture && fifo_full && !accept)     fifo_ovf <= 1'b1;
      case (state)
        ST_ARMED:    if (sm_done) state <= ST_RUN;
        ST_RUN:      if (!sm_done && fifo_empty && !accept) state <= ST_COMPLETE;
        ST_COMPLETE: state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

`ifdef WR_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || init)  checksum <= '0;
    else if (accept)    checksum <= checksum + lane_sum(fifo_head);
  end
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_softmax_result_writer.sv
// Self-checking bench for softmax_result_writer: directed runs plus randomized runs against a queue-based model.
module tb_softmax_result_writer;
  import softmax_result_writer_pkg::*;

  localparam int DEPTH = 4;
  localparam int PW    = ADDRSIZE + WORDWIDTH;

  logic                 clk = 1'b0;
  logic                 reset, init, sm_done, mem_wr_ready;
  logic [ADDRSIZE-1:0]  out_start_addr, out_end_addr;
  logic [DATAWIDTH-1:0] outp0, outp1;
  logic                 mem_wr_en, busy, complete, fifo_ovf, addr_ovr;
  logic [ADDRSIZE-1:0]  mem_wr_addr;
  logic [WORDWIDTH-1:0] mem_wr_data;
  logic [ADDRSIZE:0]    beat_count;
  logic [DATAWIDTH-1:0] checksum;
  logic [1:0]           fsm_state;

  always #5 clk = ~clk;

  softmax_result_writer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .init           (init),
    .out_start_addr (out_start_addr),
    .out_end_addr   (out_end_addr),
    .outp0          (outp0),
    .outp1          (outp1),
    .sm_done        (sm_done),
    .mem_wr_en      (mem_wr_en),
    .mem_wr_addr    (mem_wr_addr),
    .mem_wr_data    (mem_wr_data),
    .mem_wr_ready   (mem_wr_ready),
    .busy           (busy),
    .complete       (complete),
    .beat_count     (beat_count),
    .fifo_ovf       (fifo_ovf),
    .addr_ovr       (addr_ovr),
    .checksum       (checksum),
    .fsm_state      (fsm_state)
  );

  int checks = 0;
  int failures = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] got_q[$];
  int got_complete = 0;

  // Reference model: a bounded queue plus write pointer, armed/running flags and expected status.
  logic [WORDWIDTH-1:0] m_q[$];
  bit   m_armed, m_running, m_fifo_ovf, m_addr_ovr;
  int   m_ptr, m_end, m_bc, m_complete;
  logic [DATAWIDTH-1:0] m_cks;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_armed = 0; m_running = 0; m_fifo_ovf = 0; m_addr_ovr = 0;
    m_ptr = 0; m_end = 0; m_bc = 0; m_cks = '0;
  endfunction

  function automatic void model_edge(input bit done, input logic [WORDWIDTH-1:0] w, input bit rdy);
    bit pop, was_empty, do_push;
    logic [WORDWIDTH-1:0] wv;
    logic [ADDRSIZE-1:0]  a;
    pop       = m_running && (m_q.size() > 0) && rdy;
    was_empty = (m_q.size() == 0);
    do_push   = 0;
    if ((m_armed || m_running) && done) begin
      if (m_ptr + m_q.size() > m_end)         m_addr_ovr = 1;
      else if (m_q.size() == DEPTH && !pop)   m_fifo_ovf = 1;
      else                                    do_push = 1;
    end
    if (pop) begin
      wv = m_q.pop_front();
      a  = m_ptr[ADDRSIZE-1:0];
      exp_q.push_back({a, wv});
      m_ptr++;
      m_bc++;
      m_cks = m_cks + wv[DATAWIDTH-1:0] + wv[WORDWIDTH-1:DATAWIDTH];
    end
    if (do_push) m_q.push_back(w);
    if (m_armed && done) begin
      m_armed = 0; m_running = 1;
    end else if (m_running && !done && was_empty) begin
      m_running = 0; m_complete++;
    end
  endfunction

  // Write-port monitor: records accepted writes and checks that a stalled request is held.
  logic          stalled = 1'b0;
  logic [PW-1:0] stall_word;
  always @(negedge clk) begin
    if (mem_wr_en && mem_wr_ready) got_q.push_back({mem_wr_addr, mem_wr_data});
    if (complete) got_complete++;
    if (stalled) begin
      check("hold_en", mem_wr_en, 1'b1);
      check("hold_word", {mem_wr_addr, mem_wr_data}, stall_word);
    end
    stalled    = mem_wr_en && !mem_wr_ready && !init && !reset;
    stall_word = {mem_wr_addr, mem_wr_data};
  end

  task automatic step(input bit done, input logic [DATAWIDTH-1:0] o0, input logic [DATAWIDTH-1:0] o1,
                      input bit rdy);
    sm_done = done; outp0 = o0; outp1 = o1; mem_wr_ready = rdy;
    model_edge(done, {o1, o0}, rdy);
    @(posedge clk); #1;
  endtask

  task automatic do_init(input int s, input int e);
    init = 1'b1; sm_done = 1'b0; mem_wr_ready = 1'b0;
    out_start_addr = s[ADDRSIZE-1:0]; out_end_addr = e[ADDRSIZE-1:0];
    m_q.delete();
    m_armed = 1; m_running = 0; m_ptr = s; m_end = e;
    m_bc = 0; m_fifo_ovf = 0; m_addr_ovr = 0; m_cks = '0;
    @(posedge clk); #1;
    init = 1'b0;
  endtask

  task automatic drain(input bit toggle);
    int n;
    n = 0;
    while ((busy || m_running || m_armed) && n < 200) begin
      step(1'b0, '0, '0, toggle ? n[0] : 1'b1);
      n++;
    end
    check("drain_bound", n < 200, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
  endtask

  task automatic finish_run(input string tag);
    logic [DATAWIDTH-1:0] exp_cks;
`ifdef WR_CHECKSUM_EN
    exp_cks = m_cks;
`else
    exp_cks = '0;
`endif
    check({tag, "_nwrites"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_write"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete(); exp_q.delete();
    check({tag, "_beat_count"}, beat_count, m_bc);
    check({tag, "_fifo_ovf"}, fifo_ovf, m_fifo_ovf);
    check({tag, "_addr_ovr"}, addr_ovr, m_addr_ovr);
    check({tag, "_complete"}, got_complete, m_complete);
    check({tag, "_checksum"}, checksum, exp_cks);
    check({tag, "_idle"}, {busy, fsm_state}, 3'b000);
    got_complete = 0; m_complete = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, mem_wr_en, 1'b0);
    check({tag, "_wr_addr"}, mem_wr_addr, '0);
    check({tag, "_wr_data"}, mem_wr_data, '0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_complete"}, complete, 1'b0);
    check({tag, "_beat_count"}, beat_count, '0);
    check({tag, "_flags"}, {fifo_ovf, addr_ovr}, 2'b00);
    check({tag, "_checksum"}, checksum, '0);
    check({tag, "_state"}, fsm_state, ST_IDLE);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, e;
    reset = 1'b1; init = 1'b0; sm_done = 1'b0; mem_wr_ready = 1'b0;
    outp0 = '0; outp1 = '0; out_start_addr = '0; out_end_addr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Basic run: 8 beats into 10..17, ready always high.
    do_init(10, 17);
    for (int k = 0; k < 8; k++) step(1'b1, k, 100 + k, 1'b1);
    drain(1'b0);
    check("basic_bc8", beat_count, 8);
`ifdef WR_CHECKSUM_EN
    check("basic_cks856", checksum, 856);
`else
    check("basic_cks0", checksum, 0);
`endif
    finish_run("basic");

    // Beats while IDLE are ignored.
    for (int k = 0; k < 3; k++) step(1'b1, $urandom, $urandom, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    check("idle_flags", {fifo_ovf, addr_ovr}, 2'b00);
    finish_run("idle");

    // Backpressure: ready toggling, no drops.
    do_init(10, 17);
    for (int k = 0; k < 8; k++) step(1'b1, k, 100 + k, k[0]);
    drain(1'b1);
    check("bp1_fifo_ovf", fifo_ovf, 1'b0);
    finish_run("bp1");

    // Backpressure: ready low for 6 beats, last two dropped.
    do_init(10, 17);
    for (int k = 0; k < 6; k++) step(1'b1, k, 100 + k, 1'b0);
    drain(1'b0);
    check("bp2_bc4", beat_count, 4);
    check("bp2_fifo_ovf", fifo_ovf, 1'b1);
    finish_run("bp2");

    // Address bound: only 20..22 are written.
    do_init(20, 22);
    for (int k = 0; k < 5; k++) step(1'b1, $urandom, $urandom, 1'b1);
    drain(1'b0);
    check("abound_bc3", beat_count, 3);
    check("abound_addr_ovr", addr_ovr, 1'b1);
    finish_run("abound");

    // Start beyond end: everything dropped, still completes.
    do_init(30, 25);
    for (int k = 0; k < 3; k++) step(1'b1, $urandom, $urandom, 1'b1);
    drain(1'b0);
    check("inv_addr_ovr", addr_ovr, 1'b1);
    finish_run("inverted");

    // Re-init mid-run with two beats buffered.
    do_init(40, 60);
    step(1'b1, $urandom, $urandom, 1'b0);
    step(1'b1, $urandom, $urandom, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    do_init(50, 60);
    check("reinit_state", fsm_state, ST_ARMED);
    check("reinit_busy", busy, 1'b1);
    check("reinit_bc", beat_count, '0);
    check("reinit_wr_en", mem_wr_en, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, '0, '0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b1, $urandom, $urandom, 1'b1);
    drain(1'b0);
    finish_run("reinit");

    // Randomized runs with gaps in sm_done and random backpressure.
    for (int r = 0; r < 4; r++) begin
      s = $urandom_range(0, 400);
      e = s + $urandom_range(0, 12);
      do_init(s, e);
      for (int c = 0; c < 30; c++)
        step((c == 0) ? 1'b1 : ($urandom_range(0, 9) < 7), $urandom, $urandom, $urandom_range(0, 9) < 6);
      drain(1'b0);
      finish_run("rand");
    end

    // Reset wins over init and sm_done in the same cycle.
    do_init(10, 17);
    for (int k = 0; k < 3; k++) step(1'b1, $urandom, $urandom, 1'b0);
    reset = 1'b1; init = 1'b1; sm_done = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; init = 1'b0; sm_done = 1'b0;
    check_all_zero("rst_prio");
    check("rst_prio_nowrites", got_q.size(), 0);
    model_reset();
    exp_q.delete(); got_q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/softmax_result_writer.md
Name: softmax_result_writer

Overview:
- Write-back engine on the output side of the softmax datapath.
- The softmax block reads its operands from on-chip memory through address ports. This block is the return path: it captures the lane results (outp0/outp1) on every cycle the softmax done strobe is high, buffers them in a small FIFO, and writes packed words back to on-chip memory through a ready/enable write port.
- It reports completion and sticky error status to the controller.

Parameters:
- DATAWIDTH, 32, lane width (`DATAWIDTH)
- NUM, 2, lanes per memory word (`NUM)
- ADDRSIZE, 9, memory address width (`ADDRSIZE)
- FIFO_DEPTH, 4, result buffer entries; must be a power of two, ≥2

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- init  in  1  latches out_start_addr/out_end_addr, flushes FIFO, arms block
- out_start_addr  in  ADDRSIZE  first write address
- out_end_addr  in  ADDRSIZE  last valid write address (inclusive)
- outp0  in  DATAWIDTH  softmax lane-0 result
- outp1  in  DATAWIDTH  softmax lane-1 result
- sm_done  in  1  softmax result-valid strobe; one beat per high cycle
- mem_wr_en  out  1  write request
- mem_wr_addr  out  ADDRSIZE  write address
- mem_wr_data  out  DATAWIDTH*NUM  {outp1,outp0}; lane 0 occupies the LSBs
- mem_wr_ready  in  1  memory accepts the write this cycle
- busy  out  1  high in ARMED or RUN
- complete  out  1  one-cycle pulse when all beats are written
- beat_count  out  ADDRSIZE+1  beats written since init
- fifo_ovf  out  1  sticky: beat dropped because FIFO full
- addr_ovr  out  1  sticky: beat dropped because address exceeded out_end_addr
- checksum  out  DATAWIDTH  see Optional Feature

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; FIFO empty.
  - Latched start/end addresses 0; write pointer 0; sticky flags cleared.
- Reset has priority over init and over sm_done in the same cycle.
- States: IDLE, ARMED, RUN, COMPLETE.
  - Any state, init=1 → ARMED. Write pointer ← out_start_addr. FIFO flushed, beat_count and sticky flags cleared. Any beat present that cycle is dropped.
  - IDLE: sm_done is ignored. No flag is set and nothing is pushed.
  - ARMED: sm_done=1 → RUN, and that beat is pushed.
  - RUN: when sm_done=0, FIFO empty and no write accepted this cycle → COMPLETE.
  - COMPLETE: complete=1 for exactly one cycle → IDLE. sm_done in COMPLETE is ignored.
- Capture:
  - In ARMED/RUN, each cycle with sm_done=1 pushes {outp1,outp0}, sampled at that edge. The softmax registers outp and done on the same edge.
- Write:
  - mem_wr_en = state RUN & FIFO not empty. mem_wr_data is the FIFO head; mem_wr_addr is the write pointer.
  - On mem_wr_en & mem_wr_ready: pop, write pointer +1, beat_count +1.
  - mem_wr_en, addr and data are held stable until accepted.
  - Minimum latency: beat captured at edge N appears on mem_wr_en at cycle N+1 (FIFO registered, no bypass).
- Full FIFO:
  - Push and pop in the same cycle is allowed when full; the count is unchanged and no drop occurs.
  - Push when full without a pop: the beat is dropped and fifo_ovf is set.
- Address bound:
  - At push time, if (write pointer + FIFO occupancy) > out_end_addr, the beat is not pushed and addr_ovr is set. No write ever exceeds out_end_addr.
  - Write pointer arithmetic is ADDRSIZE+1 bits wide; no wrap.
- out_start_addr > out_end_addr: every beat is dropped with addr_ovr set; the block still completes.
- Sticky flags persist through COMPLETE/IDLE until init or reset.
- Continuous done bursts with mem_wr_ready always 1 sustain one write per cycle.

Optional Feature:
- Macro WR_CHECKSUM_EN.
- Defined: checksum is the wrapping DATAWIDTH-bit sum of every lane of every accepted write. It is cleared by reset/init, updated on the accept edge, and holds its value after COMPLETE.
- Undefined: checksum is tied to 0 and no adder is instantiated.

Decomposition:
- Shared package: state encoding constants (IDLE=0, ARMED=1, RUN=2, COMPLETE=3); DATAWIDTH/NUM/ADDRSIZE taken from the existing defines.
- One sub-module: softmax_wb_fifo. A synchronous FIFO with push/pop/flush, full/empty and occupancy outputs, width DATAWIDTH*NUM, depth FIFO_DEPTH.

Test Plan:
- Basic run:
  - Stimulus: init with start=10, end=17; 8 consecutive sm_done beats with outp0=k, outp1=100+k; mem_wr_ready=1.
  - Required: writes to 10..17 with data {100+k,k}; beat_count=8; complete pulses once; no flags set.
- Backpressure:
  - Stimulus: same run, mem_wr_ready toggling 1/0. Then a second run with ready=0 for 6 cycles.
  - Required: first run has no drops and addr/data held while stalled. Second run: beats 5 and 6 are dropped with fifo_ovf=1, 4 writes complete to addresses 10..13, complete still pulses.
- Address bound:
  - Stimulus: start=20, end=22; 5 beats.
  - Required: 3 writes (20, 21, 22); addr_ovr=1; beat_count=3.
- Ignored beats and re-init:
  - Stimulus: sm_done while IDLE; then init mid-RUN with 2 beats buffered.
  - Required: the IDLE beats cause no writes and no flags. After init, the FIFO is empty, beat_count=0, state is ARMED, and no stale write is issued.
- Reset priority:
  - Stimulus: reset asserted together with init and sm_done during RUN.
  - Required: the next cycle all outputs are 0 and state is IDLE.
- Checksum (WR_CHECKSUM_EN):
  - Stimulus: basic run, lanes k and 100+k for k=0..7.
  - Required: checksum=856. With the macro undefined, checksum=0.
